seven_segment_scanner: RTL and testbench

- Upstream driver for the combinational hex-to-seven-segment decoder on the 4-digit multiplexed display.
- Holds a 16-bit display value plus per-digit decimal points and time-multiplexes them one digit at a time.
- Drives the decoder's w,x,y,z nibble inputs and the active-low digit anodes, with optional leading-zero blanking.
- New values are double-buffered and applied only at a scan-frame boundary, so a frame never shows a torn value.

---
 rtl/seven_segment_scanner.sv | 112 +++++++++++
 tb/tb_seven_segment_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 4-digit multiplexed display scanner feeding a hex-to-7seg decoder
// Double-buffered value, applied only at frame boundaries; optional leading-zero blanking.
module seven_segment_scanner #(
  parameter int PRESCALE = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        dp,
  output logic        blank,
  output logic        frame_tick,
  output logic        update_ack
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [3:0]    disp_dp;
  logic [15:0]   pending;
  logic [3:0]    pending_dp;
  logic          pending_valid;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    hi_zero;
  logic          slot_blank;

  assign tick     = (count == LAST);
  assign boundary = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      idx   <= 2'd0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      if (tick) idx <= idx + 2'd1;
    end
  end

  // A load coinciding with the boundary bypasses the pending buffer so the newest data wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp          <= 16'h0000;
      disp_dp       <= 4'b0000;
      pending       <= 16'h0000;
      pending_dp    <= 4'b0000;
      pending_valid <= 1'b0;
      frame_tick    <= 1'b0;
      update_ack    <= 1'b0;
    end else begin
      frame_tick <= boundary;
      update_ack <= boundary && (load || pending_valid);
      if (boundary) begin
        pending_valid <= 1'b0;
        if (load) begin
          disp    <= data_in;
          disp_dp <= dp_in;
        end else if (pending_valid) begin
          disp    <= pending;
          disp_dp <= pending_dp;
        end
      end else if (load) begin
        pending       <= data_in;
        pending_dp    <= dp_in;
        pending_valid <= 1'b1;
      end
    end
  end

  // hi_zero[i]: digit i and everything above it are zero with no decimal points lit.
  always_comb begin
    hi_zero    = 4'b0000;
    hi_zero[3] = (disp[15:12] == 4'h0) && !disp_dp[3];
    hi_zero[2] = hi_zero[3] && (disp[11:8] == 4'h0) && !disp_dp[2];
    hi_zero[1] = hi_zero[2] && (disp[7:4] == 4'h0) && !disp_dp[1];
    hi_zero[0] = 1'b0;
  end

  always_comb begin
    nib = 4'h0;
    case (idx)
      2'd0: nib = disp[3:0];
      2'd1: nib = disp[7:4];
      2'd2: nib = disp[11:8];
      2'd3: nib = disp[15:12];
      default: nib = 4'h0;
    endcase
  end

  assign slot_blank = BLANK_LZ && hi_zero[idx];

  always_comb begin
    {w, x, y, z} = nib;
    blank        = slot_blank;
    an           = slot_blank ? 4'b1111 : ~(4'b0001 << idx);
    dp           = slot_blank ? 1'b1 : ~disp_dp[idx];
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner
// Runs a blanking and a non-blanking instance in lockstep off shared stimulus.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;

  logic       w1, x1, y1, z1, dp1, blank1, ft1, ua1;
  logic [3:0] an1;
  logic       w0, x0, y0, z0, dp0, blank0, ft0, ua0;
  logic [3:0] an0;

  int total = 0;
  int bad = 0;

  logic [11:0] q1[$];
  logic [11:0] q0[$];

  always #5 clk = ~clk;

  seven_segment_scanner #(.PRESCALE(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .w(w1), .x(x1), .y(y1), .z(z1), .an(an1), .dp(dp1), .blank(blank1),
    .frame_tick(ft1), .update_ack(ua1)
  );

  seven_segment_scanner #(.PRESCALE(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .w(w0), .x(x0), .y(y0), .z(z0), .an(an0), .dp(dp0), .blank(blank0),
    .frame_tick(ft0), .update_ack(ua0)
  );

  wire [11:0] rec1 = {ft1, ua1, an1, w1, x1, y1, z1, dp1, blank1};
  wire [11:0] rec0 = {ft0, ua0, an0, w0, x0, y0, z0, dp0, blank0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record layout: {frame_tick, update_ack, an[3:0], wxyz[3:0], dp, blank}
  function automatic logic [11:0] exp_rec(input logic [15:0] v, input logic [3:0] d, input int i,
                                          input bit blz, input bit ft, input bit ua);
    logic [15:0] sh;
    logic [3:0]  dsh;
    logic [3:0]  an_e;
    logic        bl;
    sh   = v >> (4 * i);
    dsh  = d >> i;
    bl   = blz && (i > 0) && (sh == 16'h0) && (dsh == 4'h0);
    an_e = bl ? 4'b1111 : ~(4'b0001 << i);
    return {ft, ua, an_e, sh[3:0], (bl ? 1'b1 : ~d[i]), bl};
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input bit ua);
    for (int c = 0; c < 16; c++) begin
      q1.push_back(exp_rec(v, d, c / 4, 1'b1, c == 0, ua && (c == 0)));
      q0.push_back(exp_rec(v, d, c / 4, 1'b0, c == 0, ua && (c == 0)));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1;
    data_in = v;
    dp_in = d;
    push_frame(v, d, 1'b1);
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Compares one 16-cycle frame; optionally strobes a load at frame cycle inj_at.
  task automatic run_frame(input string name, input bit wait_ack, input int inj_at,
                           input logic [15:0] inj_v, input logic [3:0] inj_dp);
    int n;
    logic [11:0] e1, e0;
    n = 0;
    @(negedge clk);
    load = 1'b0;
    if (wait_ack) begin
      while (!ua1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk({name, "_ack_timeout"}, 32'(n < 40), 32'd1);
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      if (q1.size() == 0 || q0.size() == 0) begin
        chk({name, "_queue_empty"}, 32'(q1.size()), 32'd1);
      end else begin
        e1 = q1.pop_front();
        e0 = q0.pop_front();
        chk($sformatf("%s_c%0d_lz", name, i), 32'(rec1), 32'(e1));
        chk($sformatf("%s_c%0d_nolz", name, i), 32'(rec0), 32'(e0));
      end
      if (i == inj_at) begin
        load = 1'b1;
        data_in = inj_v;
        dp_in = inj_dp;
        push_frame(inj_v, inj_dp, 1'b1);
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_out_lz", 32'(rec1), 32'(12'b0_0_1110_0000_1_0));
    chk("reset_out_nolz", 32'(rec0), 32'(12'b0_0_1110_0000_1_0));
    rst = 1'b0;

    n = 0;
    while (an0 != 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx2", 32'(n < 40), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midframe_reset_lz", 32'(rec1), 32'(12'b0_0_1110_0000_1_0));
    chk("midframe_reset_nolz", 32'(rec0), 32'(12'b0_0_1110_0000_1_0));
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an0 != 4'b1101 && n < 20);
    chk("first_tick_cycles", 32'(n), 32'd4);

    do_load(16'h1234, 4'b0000);
    run_frame("scan1234", 1'b1, -1, 16'h0, 4'h0);

    do_load(16'h0050, 4'b0000);
    run_frame("blank0050", 1'b1, -1, 16'h0, 4'h0);
    do_load(16'h0050, 4'b0100);
    run_frame("blank0050_dp2", 1'b1, -1, 16'h0, 4'h0);

    do_load(16'hAAAA, 4'b0000);
    run_frame("dbuf_old", 1'b1, 5, 16'hBBBB, 4'b0000);
    run_frame("dbuf_new", 1'b0, -1, 16'h0, 4'h0);
    push_frame(16'hBBBB, 4'b0000, 1'b0);
    run_frame("idle_then_simul", 1'b0, 15, 16'hC0DE, 4'b0000);
    run_frame("simul_c0de", 1'b0, -1, 16'h0, 4'h0);
    push_frame(16'hC0DE, 4'b0000, 1'b0);
    run_frame("after_simul_idle", 1'b0, -1, 16'h0, 4'h0);

    do_load(16'h0000, 4'b0000);
    run_frame("zero_value", 1'b1, -1, 16'h0, 4'h0);

    chk("queue_left_lz", 32'(q1.size()), 32'd0);
    chk("queue_left_nolz", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
